// File: rtl/iob_sync_pack_fifo.sv
// Narrow-write / wide-read synchronous FIFO: packs RATIO narrow words into one
// wide word held in a register-array store; flush commits a zero-padded partial word.
module iob_sync_pack_fifo #(
  parameter int unsigned W_DATA_W = 8,
  parameter int unsigned R_DATA_W = 32,
  parameter int unsigned R_ADDR_W = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [W_DATA_W-1:0]                     data_in,
  input  logic                                    write_en,
  output logic                                    full,
  input  logic                                    flush,
  input  logic                                    read_en,
  output logic [R_DATA_W-1:0]                     data_out,
  output logic                                    empty,
  output logic [R_ADDR_W:0]                       level,
  output logic [$clog2(R_DATA_W/W_DATA_W)-1:0]    pack_cnt
);

  localparam int unsigned RATIO = R_DATA_W / W_DATA_W;
  localparam int unsigned CNT_W = $clog2(RATIO);
  localparam int unsigned LVL_W = R_ADDR_W + 1;
  localparam int unsigned DEPTH = 2 ** R_ADDR_W;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

  typedef enum logic {
    S_FILL,
    S_FLUSH
  } state_t;

  state_t                r_state;
  logic [R_DATA_W-1:0]   r_pack;
  logic [CNT_W-1:0]      r_cnt;
  logic [R_ADDR_W-1:0]   r_wptr;
  logic [R_ADDR_W-1:0]   r_rptr;
  logic [LVL_W-1:0]      r_level;
  logic                  r_empty;
  logic                  r_full;
  logic [R_DATA_W-1:0]   r_dout;
  logic [R_DATA_W-1:0]   r_mem [DEPTH];

  logic                  w_wr;
  logic                  w_rd;
  logic                  w_commit;
  logic [R_DATA_W-1:0]   w_pack_wr;
  logic [R_DATA_W-1:0]   w_pack_n;
  logic [CNT_W-1:0]      w_cnt_n;
  logic [LVL_W-1:0]      w_lvl_after_rd;
  logic [LVL_W-1:0]      w_level_n;
  state_t                w_state_n;

  assign w_wr = write_en & ~r_full;
  assign w_rd = read_en & ~r_empty;
  assign w_lvl_after_rd = r_level - LVL_W'(w_rd);

  // Packer/commit decision; the packer is cleared on every commit so unfilled
  // upper slices of a flushed word are already zero.
  always_comb begin
    w_pack_wr = r_pack;
    if (w_wr) w_pack_wr[W_DATA_W*int'(r_cnt) +: W_DATA_W] = data_in;
    w_commit  = 1'b0;
    w_pack_n  = r_pack;
    w_cnt_n   = r_cnt;
    w_state_n = r_state;
    case (r_state)
      S_FILL: begin
        if (w_wr && (r_cnt == CNT_MAX)) begin
          w_commit = 1'b1;
          w_pack_n = '0;
          w_cnt_n  = '0;
        end else begin
          if (w_wr) begin
            w_pack_n = w_pack_wr;
            w_cnt_n  = r_cnt + CNT_W'(1);
          end
          if (flush && ((r_cnt != '0) || w_wr)) begin
            if (w_lvl_after_rd < DEPTH_L) begin
              w_commit = 1'b1;
              w_pack_n = '0;
              w_cnt_n  = '0;
            end else begin
              w_state_n = S_FLUSH;
            end
          end
        end
      end
      S_FLUSH: begin
        if (r_level < DEPTH_L) begin
          w_commit  = 1'b1;
          w_pack_n  = '0;
          w_cnt_n   = '0;
          w_state_n = S_FILL;
        end
      end
      default: w_state_n = S_FILL;
    endcase
    w_level_n = r_level + LVL_W'(w_commit) - LVL_W'(w_rd);
  end

  // State, pointers, counters and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FILL;
      r_pack  <= '0;
      r_cnt   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_state <= w_state_n;
      r_pack  <= w_pack_n;
      r_cnt   <= w_cnt_n;
      r_level <= w_level_n;
      r_empty <= (w_level_n == '0);
      r_full  <= (w_state_n == S_FLUSH) | ((w_level_n == DEPTH_L) & (w_cnt_n == CNT_MAX));
      if (w_commit) r_wptr <= r_wptr + R_ADDR_W'(1);
      if (w_rd) begin
        r_rptr <= r_rptr + R_ADDR_W'(1);
        r_dout <= r_mem[r_rptr];
      end
    end
  end

  // Wide-word store.
  always_ff @(posedge clk) begin
    if (!rst && w_commit) r_mem[r_wptr] <= (r_state == S_FLUSH) ? r_pack : w_pack_wr;
  end

  assign full     = r_full;
  assign empty    = r_empty;
  assign level    = r_level;
  assign pack_cnt = r_cnt;
  assign data_out = r_dout;

endmodule

// File: tb/tb_iob_sync_pack_fifo.sv
// Self-checking bench for iob_sync_pack_fifo: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_iob_sync_pack_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        write_en;
  logic        full;
  logic        flush;
  logic        read_en;
  logic [31:0] data_out;
  logic        empty;
  logic [2:0]  level;
  logic [1:0]  pack_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: committed words, bytes waiting in the packer, deferred flush.
  logic [31:0] m_q[$];
  logic [7:0]  m_pk[$];
  bit          m_pending;
  logic [31:0] m_dout;

  iob_sync_pack_fifo #(.W_DATA_W(8), .R_DATA_W(32), .R_ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .write_en(write_en), .full(full),
    .flush(flush), .read_en(read_en), .data_out(data_out), .empty(empty),
    .level(level), .pack_cnt(pack_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] packed_word();
    logic [31:0] w = 32'h0;
    for (int i = 0; i < m_pk.size(); i++) w = w | (32'(m_pk[i]) << (8 * i));
    return w;
  endfunction

  function automatic bit m_full();
    return m_pending || (m_q.size() == 4 && m_pk.size() == 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pk.delete();
    m_pending = 1'b0;
    m_dout = 32'h0;
  endtask

  // One clock edge of the reference behaviour, using the inputs currently driven.
  task automatic model_edge();
    int  lvl0 = m_q.size();
    bit  wr = write_en && !m_full();
    bit  rd = read_en && (lvl0 != 0);
    if (rd) m_dout = m_q.pop_front();
    if (m_pending) begin
      if (lvl0 < 4) begin
        m_q.push_back(packed_word());
        m_pk.delete();
        m_pending = 1'b0;
      end
    end else begin
      if (wr) m_pk.push_back(data_in);
      if (m_pk.size() == 4) begin
        m_q.push_back(packed_word());
        m_pk.delete();
      end else if (flush && m_pk.size() > 0) begin
        if (lvl0 - int'(rd) < 4) begin
          m_q.push_back(packed_word());
          m_pk.delete();
        end else begin
          m_pending = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("level",    32'(level),    32'(m_q.size()));
    chk("pack_cnt", 32'(pack_cnt), 32'(m_pk.size()));
    chk("empty",    32'(empty),    32'(m_q.size() == 0));
    chk("full",     32'(full),     32'(m_full()));
    chk("data_out", data_out,      m_dout);
  endtask

  task automatic step(input logic we, input logic [7:0] d, input logic fl, input logic re);
    write_en = we;
    data_in  = d;
    flush    = fl;
    read_en  = re;
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    rst = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic rd_word();
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; write_en = 1'b0; data_in = 8'h00; flush = 1'b0; read_en = 1'b0;
    model_reset();

    // Reset state
    do_reset();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_dout", data_out, 32'h0);

    // Basic packing order and read latency
    wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33); wr_byte(8'h44);
    chk("pack_level", 32'(level), 32'd1);
    chk("pack_empty", 32'(empty), 32'd0);
    rd_word();
    chk("pack_dout", data_out, 32'h44332211);
    chk("pack_empty_after", 32'(empty), 32'd1);

    // Fill to full, blocked write, release by one read
    for (int i = 0; i < 19; i++) wr_byte(8'(i + 1));
    chk("fill_level", 32'(level), 32'd4);
    chk("fill_cnt", 32'(pack_cnt), 32'd3);
    chk("fill_full", 32'(full), 32'd1);
    wr_byte(8'h14);
    chk("blocked_cnt", 32'(pack_cnt), 32'd3);
    rd_word();
    chk("release_full", 32'(full), 32'd0);
    chk("release_dout", data_out, 32'h04030201);
    wr_byte(8'h14);
    chk("refill_level", 32'(level), 32'd4);
    chk("refill_cnt", 32'(pack_cnt), 32'd0);
    for (int i = 0; i < 4; i++) rd_word();
    chk("fill_last", data_out, 32'h14131211);

    // Flush of a partial word, then flush with an empty packer
    wr_byte(8'hAA); wr_byte(8'hBB);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_level", 32'(level), 32'd1);
    chk("flush_cnt", 32'(pack_cnt), 32'd0);
    rd_word();
    chk("flush_dout", data_out, 32'h0000BBAA);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_empty_level", 32'(level), 32'd0);

    // Flush while the store is full
    for (int i = 0; i < 18; i++) wr_byte(8'(8'h40 + i));
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ff_full", 32'(full), 32'd1);
    rd_word();
    chk("ff_still_full", 32'(full), 32'd1);
    idle();
    chk("ff_commit_full", 32'(full), 32'd0);
    chk("ff_commit_level", 32'(level), 32'd4);
    for (int i = 0; i < 4; i++) rd_word();
    chk("ff_last", data_out, 32'h00005150);

    // Simultaneous commit and read at level 2, then ordered words across wraps
    for (int i = 0; i < 11; i++) wr_byte(8'(8'h60 + i));
    step(1'b1, 8'h6B, 1'b0, 1'b1);
    chk("sim_level", 32'(level), 32'd2);
    chk("sim_dout", data_out, 32'h63626160);
    for (int w = 0; w < 12; w++) begin
      for (int b = 0; b < 4; b++) step(1'b1, 8'(w * 4 + b), 1'b0, b == 3);
    end
    while (!empty) rd_word();
    chk("wrap_last", data_out, 32'h2F2E2D2C);

    // Reset mid-operation
    for (int i = 0; i < 11; i++) wr_byte(8'(8'hC0 + i));
    chk("pre_rst_level", 32'(level), 32'd2);
    do_reset();
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_dout", data_out, 32'h0);
    wr_byte(8'h01); wr_byte(8'h02); wr_byte(8'h03); wr_byte(8'h04);
    rd_word();
    chk("fresh_word", data_out, 32'h04030201);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 8),
           1'($urandom_range(0, 99) < 40));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
